uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx_pkg.sv | 17 +
 rtl/uart_rx_sync_2ff.sv | 25 ++
 rtl/uart_rx.sv | 161 ++++++++++++++++
 tb/tb_uart_rx.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared UART definitions: default bit timing, data width and RX state encodings.
package uart_rx_pkg;

    // 50 MHz system clock at 115200 baud
    localparam int CLK_PER_BIT_DEFAULT = 434;
    localparam int DATA_BITS           = 8;

    // Receiver state encodings, shared with the transmitter side
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_START   = 3'd1,
        ST_DATA    = 3'd2,
        ST_STOP    = 3'd3,
        ST_RECOVER = 3'd4
    } rx_state_t;

endpackage

// File: rtl/uart_rx_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input, with a selectable
// reset value so an idle-high line does not look like activity after reset.
module sync_2ff #(
    parameter logic RESET_VALUE = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // Two-stage capture of the asynchronous input
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= RESET_VALUE;
            q    <= RESET_VALUE;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8N1, LSB first. Single FSM with one cycle counter; each bit
// is sampled once at its centre (start bit checked at half a bit period).
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int CLK_PER_BIT = CLK_PER_BIT_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_serial,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_active,
    output logic       rx_frame_err
);

    localparam int CW = $clog2(CLK_PER_BIT);
    localparam int IW = $clog2(DATA_BITS);

    localparam logic [CW-1:0] CNT_ZERO = CW'(0);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_HALF = CW'((CLK_PER_BIT - 1) / 2);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLK_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_ZERO = IW'(0);
    localparam logic [IW-1:0] IDX_ONE  = IW'(1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

    logic                 rx_s;
    rx_state_t            state, state_nxt;
    logic [CW-1:0]        cnt, cnt_nxt;
    logic [IW-1:0]        bit_idx, bit_idx_nxt;
    logic [DATA_BITS-1:0] shift, shift_nxt;
    logic [7:0]           data_nxt;
    logic                 valid_nxt;
    logic                 ferr_nxt;
    logic                 active_nxt;

    sync_2ff #(
        .RESET_VALUE (1'b1)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx_serial),
        .q   (rx_s)
    );

    // State, datapath and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            cnt          <= CNT_ZERO;
            bit_idx      <= IDX_ZERO;
            shift        <= 8'h00;
            rx_data      <= 8'h00;
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;
            rx_active    <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            bit_idx      <= bit_idx_nxt;
            shift        <= shift_nxt;
            rx_data      <= data_nxt;
            rx_valid     <= valid_nxt;
            rx_frame_err <= ferr_nxt;
            rx_active    <= active_nxt;
        end
    end

    // Next-state, counter, shift register and output pulse decode
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        bit_idx_nxt = bit_idx;
        shift_nxt   = shift;
        data_nxt    = rx_data;
        valid_nxt   = 1'b0;
        ferr_nxt    = 1'b0;

        case (state)
            ST_IDLE: begin
                cnt_nxt = CNT_ZERO;
                if (!rx_s) begin
                    state_nxt = ST_START;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end

            ST_START: begin
                if (cnt == CNT_HALF) begin
                    cnt_nxt     = CNT_ZERO;
                    bit_idx_nxt = IDX_ZERO;
                    if (!rx_s) begin
                        state_nxt = ST_DATA;
                    end else begin
                        // Start bit did not survive to mid-bit: treat as a glitch
                        state_nxt = ST_IDLE;
                    end
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end

            ST_DATA: begin
                if (cnt == CNT_LAST) begin
                    cnt_nxt            = CNT_ZERO;
                    shift_nxt[bit_idx] = rx_s;
                    if (bit_idx == IDX_LAST) begin
                        bit_idx_nxt = IDX_ZERO;
                        state_nxt   = ST_STOP;
                    end else begin
                        bit_idx_nxt = bit_idx + IDX_ONE;
                    end
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end

            ST_STOP: begin
                // Leaving at mid-stop-bit leaves half a bit to catch a
                // back-to-back start edge
                if (cnt == CNT_LAST) begin
                    cnt_nxt = CNT_ZERO;
                    if (rx_s) begin
                        data_nxt  = shift;
                        valid_nxt = 1'b1;
                        state_nxt = ST_IDLE;
                    end else begin
                        ferr_nxt  = 1'b1;
                        state_nxt = ST_RECOVER;
                    end
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end

            ST_RECOVER: begin
                // A held-low (break) line must go high before a new frame
                cnt_nxt = CNT_ZERO;
                if (rx_s) begin
                    state_nxt = ST_IDLE;
                end else begin
                    state_nxt = ST_RECOVER;
                end
            end

            default: begin
                state_nxt   = ST_IDLE;
                cnt_nxt     = CNT_ZERO;
                bit_idx_nxt = IDX_ZERO;
            end
        endcase

        case (state_nxt)
            ST_START, ST_DATA, ST_STOP: active_nxt = 1'b1;
            default:                    active_nxt = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed testbench for uart_rx: a bench-side serial transmitter drives the
// line, expected bytes go into a scoreboard queue, and a monitor collects
// what the receiver produces for comparison.
module tb_uart_rx;

    localparam int CPB     = 434;
    localparam int HALF    = (CPB - 1) / 2;
    localparam int LAT_MIN = 9 * CPB + HALF + 3;
    localparam int LAT_MAX = 9 * CPB + HALF + 5;

    logic       clk;
    logic       rst;
    logic       rx_serial;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_active;
    logic       rx_frame_err;

    int tests_run = 0;
    int tests_failed = 0;

    // Monitor-owned bookkeeping
    int         cyc = 0;
    int         valid_cnt = 0;
    int         ferr_cnt = 0;
    int         both_cnt = 0;
    int         long_cnt = 0;
    int         active_cnt = 0;
    int         valid_cyc = 0;
    logic       prev_valid = 1'b0;
    logic       prev_ferr = 1'b0;
    logic [7:0] got_q[$];

    // Stimulus-owned scoreboard
    logic [7:0] exp_q[$];
    int         fall_cyc = 0;

    uart_rx #(
        .CLK_PER_BIT (CPB)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_serial    (rx_serial),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_active    (rx_active),
        .rx_frame_err (rx_frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Free-running cycle count
    always @(posedge clk) cyc <= cyc + 1;

    // Sample outputs on the falling edge and record receiver events
    always @(negedge clk) begin
        if (rx_valid) begin
            got_q.push_back(rx_data);
            valid_cnt = valid_cnt + 1;
            valid_cyc = cyc;
        end
        if (rx_frame_err) ferr_cnt = ferr_cnt + 1;
        if (rx_valid && rx_frame_err) both_cnt = both_cnt + 1;
        if ((rx_valid && prev_valid) || (rx_frame_err && prev_ferr)) long_cnt = long_cnt + 1;
        if (rx_active) active_cnt = active_cnt + 1;
        prev_valid = rx_valid;
        prev_ferr  = rx_frame_err;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run = tests_run + 1;
        assert (obs === exp) else begin
            tests_failed = tests_failed + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_bits(input int n);
        repeat (n * CPB) @(negedge clk);
    endtask

    // Drive one 8N1 frame; the line is left at the stop-bit level
    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        @(negedge clk);
        fall_cyc  = cyc;
        rx_serial = 1'b0;
        repeat (CPB - 1) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            rx_serial = b[i];
            repeat (CPB - 1) @(negedge clk);
        end
        @(negedge clk);
        rx_serial = stop_bit;
        repeat (CPB - 1) @(negedge clk);
    endtask

    // Compare every received byte against the scoreboard, in order
    task automatic drain(input string tag);
        logic [7:0] e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (got_q.size() == 0) begin
                check({tag, "_missing"}, 32'd0, 32'd1);
            end else begin
                check({tag, "_data"}, {24'd0, got_q.pop_front()}, {24'd0, e});
            end
        end
        check({tag, "_extra"}, got_q.size(), 32'd0);
    endtask

    int v0, f0, a0;

    initial begin
        rst       = 1'b1;
        rx_serial = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_data",   {24'd0, rx_data}, 32'h00);
        check("rst_valid",  {31'd0, rx_valid}, 32'd0);
        check("rst_active", {31'd0, rx_active}, 32'd0);
        check("rst_ferr",   {31'd0, rx_frame_err}, 32'd0);
        rst = 1'b0;
        repeat (20) @(negedge clk);

        // Single frame 0xAA: data, latency, active window
        a0 = active_cnt;
        exp_q.push_back(8'hAA);
        send_byte(8'hAA, 1'b1);
        repeat (CPB) @(negedge clk);
        drain("aa");
        check("aa_latency", ((valid_cyc - fall_cyc) >= LAT_MIN && (valid_cyc - fall_cyc) <= LAT_MAX), 32'd1);
        check("aa_active", ((active_cnt - a0) >= 9 * CPB + HALF - 8 && (active_cnt - a0) <= 9 * CPB + HALF + 8), 32'd1);
        check("aa_rxdata", {24'd0, rx_data}, 32'hAA);

        // Back-to-back frames with no idle gap
        v0 = valid_cnt;
        exp_q.push_back(8'h00);
        send_byte(8'h00, 1'b1);
        exp_q.push_back(8'hFF);
        send_byte(8'hFF, 1'b1);
        exp_q.push_back(8'h5A);
        send_byte(8'h5A, 1'b1);
        repeat (CPB) @(negedge clk);
        check("b2b_count", valid_cnt - v0, 32'd3);
        drain("b2b");

        // Short low glitch must be rejected without side effects
        v0 = valid_cnt;
        f0 = ferr_cnt;
        @(negedge clk);
        rx_serial = 1'b0;
        repeat (100) @(negedge clk);
        rx_serial = 1'b1;
        wait_bits(2);
        check("glitch_valid",  valid_cnt - v0, 32'd0);
        check("glitch_ferr",   ferr_cnt - f0, 32'd0);
        check("glitch_data",   {24'd0, rx_data}, 32'h5A);
        check("glitch_active", {31'd0, rx_active}, 32'd0);
        exp_q.push_back(8'h96);
        send_byte(8'h96, 1'b1);
        repeat (CPB) @(negedge clk);
        drain("post_glitch");

        // Framing error followed by a held-low break line
        v0 = valid_cnt;
        f0 = ferr_cnt;
        send_byte(8'h3C, 1'b0);
        wait_bits(20);
        check("ferr_pulse",  ferr_cnt - f0, 32'd1);
        check("ferr_valid",  valid_cnt - v0, 32'd0);
        check("ferr_data",   {24'd0, rx_data}, 32'h96);
        check("ferr_active", {31'd0, rx_active}, 32'd0);
        rx_serial = 1'b1;
        wait_bits(1);
        exp_q.push_back(8'h81);
        send_byte(8'h81, 1'b1);
        repeat (CPB) @(negedge clk);
        drain("post_ferr");

        // Reset in the middle of data bit 4 of 0xC3
        v0 = valid_cnt;
        f0 = ferr_cnt;
        @(negedge clk);
        rx_serial = 1'b0;
        repeat (CPB - 1) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            rx_serial = (i == 0 || i == 1) ? 1'b1 : 1'b0;
            repeat (CPB - 1) @(negedge clk);
        end
        @(negedge clk);
        rx_serial = 1'b0;
        repeat (CPB / 2) @(negedge clk);
        check("mid_active_before", {31'd0, rx_active}, 32'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_data",   {24'd0, rx_data}, 32'h00);
        check("mid_rst_valid",  {31'd0, rx_valid}, 32'd0);
        check("mid_rst_active", {31'd0, rx_active}, 32'd0);
        check("mid_rst_ferr",   {31'd0, rx_frame_err}, 32'd0);
        repeat (3) @(negedge clk);
        rst       = 1'b0;
        rx_serial = 1'b1;
        wait_bits(6);
        check("mid_no_valid", valid_cnt - v0, 32'd0);
        check("mid_no_ferr",  ferr_cnt - f0, 32'd0);
        exp_q.push_back(8'h7E);
        send_byte(8'h7E, 1'b1);
        repeat (CPB) @(negedge clk);
        drain("post_rst");
        check("post_rst_data", {24'd0, rx_data}, 32'h7E);

        // Pulse integrity over the whole run
        check("valid_ferr_overlap", both_cnt, 32'd0);
        check("pulse_width",        long_cnt, 32'd0);
        check("total_ferr",         ferr_cnt, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
